l2_client_arbiter: RTL



---
 rtl/l2_client_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/l2_client_arbiter.sv
// N-client front end for the shared L2: latches miss requests, grants one client at a time,
// routes the L2 response back, and sequences hierarchy flushes. L2ARB_FIXED_PRIO_EN selects fixed priority.
module l2_client_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int OPC_W     = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [N_CLIENTS-1:0]                              cl_req_valid,
    input  logic [N_CLIENTS*ADDR_W-1:0]                       cl_req_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]                       cl_req_store_data,
    input  logic [N_CLIENTS*OPC_W-1:0]                        cl_req_opcode,
    output logic [N_CLIENTS-1:0]                              cl_rsp_valid,
    input  logic [N_CLIENTS-1:0]                              cl_flush_req,
    input  logic [N_CLIENTS-1:0]                              cl_flush_complete,
    output logic                                              l2_req_valid,
    input  logic                                              l2_req_ack,
    output logic [ADDR_W-1:0]                                 l2_req_addr,
    output logic [DATA_W-1:0]                                 l2_req_store_data,
    output logic [OPC_W-1:0]                                  l2_req_opcode,
    input  logic                                              l2_rsp_valid,
    output logic                                              l2_flush_req,
    input  logic                                              l2_flush_complete,
    output logic                                              in_flush_mode,
    output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] gnt_id
);
    localparam int GNT_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic {ST_IDLE, ST_GNT} arb_state_t;
    typedef enum logic [1:0] {FL_IDLE, FL_WAIT, FL_L2} fl_state_t;

    arb_state_t              r_arb_state, w_arb_next;
    fl_state_t               r_fl_state, w_fl_next;
    logic                    r_req_valid, w_req_valid_next;
    logic [N_CLIENTS-1:0]    r_pending, w_pending_next, w_req_eff;
    logic [GNT_W-1:0]        r_gnt_id, w_gnt_next, w_winner;
    logic [N_CLIENTS-1:0]    w_win_onehot, w_gnt_onehot;
    logic                    w_found;
    logic [N_CLIENTS-1:0]    r_req_mask, w_req_mask_next;
    logic [N_CLIENTS-1:0]    r_done_mask, w_done_mask_next;
    logic                    r_in_flush, w_in_flush_next;
    logic [31:0]             w_sel;

    assign w_req_eff = r_pending | cl_req_valid;

`ifdef L2ARB_FIXED_PRIO_EN
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_win_onehot = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            if (!w_found && w_req_eff[k]) begin
                w_found         = 1'b1;
                w_winner        = GNT_W'(k);
                w_win_onehot[k] = 1'b1;
            end
        end
    end
`else
    logic [GNT_W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= GNT_W'(N_CLIENTS - 1);
        else if (r_arb_state == ST_IDLE && w_found)
            r_last <= w_winner;
    end

    // Two passes (above last, then up to last) give the rotate-from-(last+1) order without a modulo.
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_win_onehot = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            if (!w_found && w_req_eff[k] && k > 32'(r_last)) begin
                w_found         = 1'b1;
                w_winner        = GNT_W'(k);
                w_win_onehot[k] = 1'b1;
            end
        end
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            if (!w_found && w_req_eff[k] && k <= 32'(r_last)) begin
                w_found         = 1'b1;
                w_winner        = GNT_W'(k);
                w_win_onehot[k] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_gnt_onehot = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++)
            w_gnt_onehot[k] = (32'(r_gnt_id) == k);
    end

    always_comb begin
        w_arb_next       = r_arb_state;
        w_req_valid_next = r_req_valid;
        w_pending_next   = r_pending;
        w_gnt_next       = r_gnt_id;
        cl_rsp_valid     = '0;
        case (r_arb_state)
            ST_IDLE: begin
                w_pending_next = w_req_eff & ~w_win_onehot;
                if (w_found) begin
                    w_gnt_next       = w_winner;
                    w_req_valid_next = 1'b1;
                    w_arb_next       = ST_GNT;
                end
            end
            ST_GNT: begin
                // A repeat pulse from the client already being served is dropped.
                w_pending_next = r_pending | (cl_req_valid & ~w_gnt_onehot);
                if (l2_rsp_valid) begin
                    cl_rsp_valid     = w_gnt_onehot;
                    w_req_valid_next = 1'b0;
                    w_arb_next       = ST_IDLE;
                end else if (l2_req_ack) begin
                    w_req_valid_next = 1'b0;
                end
            end
            default: w_arb_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fl_next        = r_fl_state;
        w_req_mask_next  = r_req_mask;
        w_done_mask_next = r_done_mask;
        w_in_flush_next  = r_in_flush;
        l2_flush_req     = 1'b0;
        case (r_fl_state)
            FL_IDLE: begin
                if (|cl_flush_req) begin
                    w_req_mask_next  = cl_flush_req;
                    w_done_mask_next = '0;
                    w_in_flush_next  = 1'b1;
                    w_fl_next        = FL_WAIT;
                end
            end
            FL_WAIT: begin
                w_done_mask_next = r_done_mask | cl_flush_complete;
                if (&(r_done_mask | cl_flush_complete | ~r_req_mask)) begin
                    l2_flush_req = 1'b1;
                    w_fl_next    = FL_L2;
                end
            end
            FL_L2: begin
                if (l2_flush_complete) begin
                    w_in_flush_next = 1'b0;
                    w_fl_next       = FL_IDLE;
                end
            end
            default: w_fl_next = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arb_state <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_pending   <= '0;
            r_gnt_id    <= '0;
            r_fl_state  <= FL_IDLE;
            r_req_mask  <= '0;
            r_done_mask <= '0;
            r_in_flush  <= 1'b0;
        end else begin
            r_arb_state <= w_arb_next;
            r_req_valid <= w_req_valid_next;
            r_pending   <= w_pending_next;
            r_gnt_id    <= w_gnt_next;
            r_fl_state  <= w_fl_next;
            r_req_mask  <= w_req_mask_next;
            r_done_mask <= w_done_mask_next;
            r_in_flush  <= w_in_flush_next;
        end
    end

    assign w_sel             = 32'(r_gnt_id);
    assign l2_req_addr       = cl_req_addr[w_sel*ADDR_W +: ADDR_W];
    assign l2_req_store_data = cl_req_store_data[w_sel*DATA_W +: DATA_W];
    assign l2_req_opcode     = cl_req_opcode[w_sel*OPC_W +: OPC_W];
    assign l2_req_valid      = r_req_valid;
    assign in_flush_mode     = r_in_flush;
    assign gnt_id            = r_gnt_id;

endmodule
